// File: rtl/cache_stage_if.sv
// Bus between the TLB-lookup stage and the data-cache stage. The TLB-lookup
// side drives the instruction fields and the fill controls. The cache stage
// returns the result and the destination fields to WB and the bypass mux.
interface cache_stage_if #(
    parameter int CACHE_LINE_WIDTH = 256,
    parameter int WORD_WIDTH       = 16,
    parameter int ADDR_WIDTH       = 16,
    parameter int NUM_CACHE_LINES  = 4
);
    logic                        enable_cache;
    logic [ADDR_WIDTH-1:0]       tlblookup_result;
    logic [WORD_WIDTH-1:0]       dataReg;
    logic [1:0]                  ldSt_enable;
    logic [2:0]                  destReg_addr_input;
    logic                        we_input;
    logic                        petitionToData;
    logic [NUM_CACHE_LINES-1:0]  lineIdData;
    logic                        writeEnableData;
    logic [CACHE_LINE_WIDTH-1:0] memLineData;
    logic [WORD_WIDTH-1:0]       cache_result;
    logic [2:0]                  destReg_addr_output;
    logic                        we_output;

    modport master (
        output enable_cache, tlblookup_result, dataReg, ldSt_enable,
               destReg_addr_input, we_input, petitionToData, lineIdData,
               writeEnableData, memLineData,
        input  cache_result, destReg_addr_output, we_output
    );

    modport slave (
        input  enable_cache, tlblookup_result, dataReg, ldSt_enable,
               destReg_addr_input, we_input, petitionToData, lineIdData,
               writeEnableData, memLineData,
        output cache_result, destReg_addr_output, we_output
    );
endinterface

// File: rtl/cache_stage.sv
// Data-cache access stage. Registers the instruction coming out of TLB-lookup,
// holds the data array, performs word loads/stores on the line chosen by the
// tag logic and writes memory line fills.
module cache_stage #(
    parameter int CACHE_LINE_WIDTH = 256,
    parameter int WORD_WIDTH       = 16,
    parameter int ADDR_WIDTH       = 16,
    parameter int NUM_CACHE_LINES  = 4
) (
    input  logic         clk,
    input  logic         reset,
    cache_stage_if.slave bus
);
    localparam int WORDS_PER_LINE = CACHE_LINE_WIDTH / WORD_WIDTH;
    localparam int OFF_W          = $clog2(WORDS_PER_LINE);
    localparam int BIT_W          = $clog2(CACHE_LINE_WIDTH);
    localparam int WORD_SHIFT     = $clog2(WORD_WIDTH);

    logic [ADDR_WIDTH-1:0]      addr_reg;
    logic [WORD_WIDTH-1:0]      store_data_reg;
    logic [1:0]                 ldst_reg;
    logic [2:0]                 dest_reg;
    logic                       we_reg;
    logic [NUM_CACHE_LINES-1:0] line_id_reg;
    logic                       petition_reg;

    logic [NUM_CACHE_LINES-1:0]  fill_onehot;
    logic [NUM_CACHE_LINES-1:0]  line_onehot;
    logic                        store_hit;
    logic                        load_hit;
    logic [OFF_W-1:0]            offset;
    logic [BIT_W-1:0]            word_base;
    logic [CACHE_LINE_WIDTH-1:0] line_data [NUM_CACHE_LINES];
    logic [WORD_WIDTH-1:0]       load_word;
    logic [WORD_WIDTH-1:0]       result_next;

    // Stage register: capture the TLB-lookup outputs when enabled, else hold
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_reg       <= '0;
            store_data_reg <= '0;
            ldst_reg       <= '0;
            dest_reg       <= '0;
            we_reg         <= 1'b0;
            line_id_reg    <= '0;
            petition_reg   <= 1'b0;
        end else if (bus.enable_cache) begin
            addr_reg       <= bus.tlblookup_result;
            store_data_reg <= bus.dataReg;
            ldst_reg       <= bus.ldSt_enable;
            dest_reg       <= bus.destReg_addr_input;
            we_reg         <= bus.we_input;
            line_id_reg    <= bus.lineIdData;
            petition_reg   <= bus.petitionToData;
        end
    end

    // Lowest set bit wins when more than one line id bit is raised; an
    // all-zero id yields an all-zero select, which turns the access into a nop.
    assign fill_onehot = bus.lineIdData & (~bus.lineIdData + NUM_CACHE_LINES'(1));
    assign line_onehot = line_id_reg & (~line_id_reg + NUM_CACHE_LINES'(1));
    assign store_hit   = petition_reg && (ldst_reg == 2'b10);
    assign load_hit    = petition_reg && (ldst_reg == 2'b01);
    // addr[0] is a byte bit and is ignored: accesses are whole words
    assign offset      = addr_reg[OFF_W:1];
    assign word_base   = BIT_W'(offset) << WORD_SHIFT;

    generate
        for (genvar gi = 0; gi < NUM_CACHE_LINES; gi++) begin : g_line
            logic [CACHE_LINE_WIDTH-1:0] line_q;

            // Fill first, then the store word overlays it on a same-edge collision
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    line_q <= '0;
                end else begin
                    if (bus.writeEnableData && fill_onehot[gi])
                        line_q <= bus.memLineData;
                    if (store_hit && line_onehot[gi])
                        line_q[word_base +: WORD_WIDTH] <= store_data_reg;
                end
            end

            assign line_data[gi] = line_q;
        end
    endgenerate

    // Combinational word read from the selected line's current contents
    always_comb begin
        load_word = '0;
        for (int i = 0; i < NUM_CACHE_LINES; i++) begin
            if (line_onehot[i])
                load_word = load_word | line_data[i][word_base +: WORD_WIDTH];
        end
    end

    // Result mux: load data, address for stores and ALU ops, zero for bubbles
    always_comb begin
        result_next = '0;
        case (ldst_reg)
            2'b00:   result_next = addr_reg;
            2'b01:   result_next = load_hit ? load_word : '0;
            2'b10:   result_next = petition_reg ? addr_reg : '0;
            default: result_next = '0;
        endcase
    end

    assign bus.cache_result        = result_next;
    assign bus.destReg_addr_output = dest_reg;
    assign bus.we_output           = we_reg;
endmodule

// File: tb/tb_cache_stage.sv
// Self-checking bench for cache_stage: directed scenarios followed by random
// traffic, all checked against a word-array reference model.
module tb_cache_stage;
    logic clk;
    logic reset;

    cache_stage_if bus ();

    cache_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic [1:0]  ldst;
        logic [2:0]  dest;
        logic        we;
        logic [3:0]  lid;
        logic        pet;
    } op_t;

    logic [15:0] m_mem [4][16];
    op_t         m_op;
    int          n_checks;
    int          n_pass;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int l = 0; l < 4; l++)
            for (int w = 0; w < 16; w++) m_mem[l][w] = 16'h0;
        m_op = '{addr: 16'h0, data: 16'h0, ldst: 2'b00, dest: 3'd0, we: 1'b0, lid: 4'h0, pet: 1'b0};
    endtask

    function automatic logic [15:0] exp_result();
        int l;
        l = lowest(m_op.lid);
        case (m_op.ldst)
            2'b00: return m_op.addr;
            2'b01: return (m_op.pet && l >= 0) ? m_mem[l][m_op.addr[4:1]] : 16'h0;
            2'b10: return m_op.pet ? m_op.addr : 16'h0;
            default: return 16'h0;
        endcase
    endfunction

    // What happens at one rising edge: fill, store overlay, stage capture
    task automatic model_edge();
        int fl;
        int sl;
        fl = lowest(bus.lineIdData);
        if (bus.writeEnableData && fl >= 0)
            for (int w = 0; w < 16; w++) m_mem[fl][w] = bus.memLineData[w*16 +: 16];
        sl = lowest(m_op.lid);
        if (m_op.ldst == 2'b10 && m_op.pet && sl >= 0)
            m_mem[sl][m_op.addr[4:1]] = m_op.data;
        if (bus.enable_cache) begin
            m_op.addr = bus.tlblookup_result;
            m_op.data = bus.dataReg;
            m_op.ldst = bus.ldSt_enable;
            m_op.dest = bus.destReg_addr_input;
            m_op.we   = bus.we_input;
            m_op.lid  = bus.lineIdData;
            m_op.pet  = bus.petitionToData;
        end
    endtask

    task automatic drive(input logic en, input logic [15:0] addr, input logic [15:0] data,
                         input logic [1:0] ldst, input logic [2:0] dest, input logic we,
                         input logic pet, input logic [3:0] lid, input logic wed,
                         input logic [255:0] line);
        bus.enable_cache       = en;
        bus.tlblookup_result   = addr;
        bus.dataReg            = data;
        bus.ldSt_enable        = ldst;
        bus.destReg_addr_input = dest;
        bus.we_input           = we;
        bus.petitionToData     = pet;
        bus.lineIdData         = lid;
        bus.writeEnableData    = wed;
        bus.memLineData        = line;
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check({tag, "_result"}, bus.cache_result, exp_result());
        check({tag, "_dest"}, {13'b0, bus.destReg_addr_output}, {13'b0, m_op.dest});
        check({tag, "_we"}, {15'b0, bus.we_output}, {15'b0, m_op.we});
    endtask

    function automatic logic [255:0] ramp_line(input logic [15:0] base);
        logic [255:0] v;
        for (int w = 0; w < 16; w++) v[w*16 +: 16] = base + 16'(w);
        return v;
    endfunction

    function automatic logic [255:0] flat_line(input logic [15:0] val);
        logic [255:0] v;
        for (int w = 0; w < 16; w++) v[w*16 +: 16] = val;
        return v;
    endfunction

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b0;
        drive(1'b1, 16'h0, 16'h0, 2'b00, 3'd0, 1'b0, 1'b0, 4'h0, 1'b0, '0);
        model_reset();
        #1;
        check("rst_result", bus.cache_result, 16'h0);
        check("rst_dest", {13'b0, bus.destReg_addr_output}, 16'h0);
        check("rst_we", {15'b0, bus.we_output}, 16'h0);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;

        // Fill line 2 with a ramp, then load word 3
        drive(1'b1, 16'h0, 16'h0, 2'b00, 3'd0, 1'b0, 1'b0, 4'b0100, 1'b1, ramp_line(16'h1000));
        tick("fill2");
        drive(1'b1, 16'h0006, 16'h0, 2'b01, 3'd1, 1'b1, 1'b1, 4'b0100, 1'b0, '0);
        tick("load2");
        check("load2_const", bus.cache_result, 16'h1003);

        // Store then immediate load of the same word on line 1
        drive(1'b1, 16'h001E, 16'hBEEF, 2'b10, 3'd0, 1'b0, 1'b1, 4'b0010, 1'b0, '0);
        tick("st1");
        drive(1'b1, 16'h001E, 16'h0, 2'b01, 3'd2, 1'b1, 1'b1, 4'b0010, 1'b0, '0);
        tick("ldst1");
        check("st_ld_const", bus.cache_result, 16'hBEEF);
        drive(1'b1, 16'h001C, 16'h0, 2'b01, 3'd2, 1'b1, 1'b1, 4'b0010, 1'b0, '0);
        tick("ld1_other");
        check("ld1_other_const", bus.cache_result, 16'h0000);

        // Fill and store collide on line 3; the store word wins
        drive(1'b1, 16'h0000, 16'hAAAA, 2'b10, 3'd0, 1'b0, 1'b1, 4'b1000, 1'b0, '0);
        tick("st3");
        drive(1'b1, 16'h0000, 16'h0, 2'b01, 3'd3, 1'b1, 1'b1, 4'b1000, 1'b1, flat_line(16'h5555));
        tick("coll");
        check("coll_w0", bus.cache_result, 16'hAAAA);
        drive(1'b1, 16'h0002, 16'h0, 2'b01, 3'd3, 1'b1, 1'b1, 4'b1000, 1'b0, '0);
        tick("coll_w1");
        check("coll_w1_const", bus.cache_result, 16'h5555);
        drive(1'b1, 16'h001F, 16'h0, 2'b01, 3'd3, 1'b1, 1'b1, 4'b1000, 1'b0, '0);
        tick("coll_w15");
        check("coll_w15_const", bus.cache_result, 16'h5555);

        // Held load during a stall; a fill under the stall shows through
        drive(1'b1, 16'h0004, 16'h0, 2'b01, 3'd4, 1'b1, 1'b1, 4'b0100, 1'b0, '0);
        tick("hold");
        check("hold_const", bus.cache_result, 16'h1002);
        drive(1'b0, 16'h0010, 16'h0, 2'b00, 3'd7, 1'b0, 1'b0, 4'b0001, 1'b0, '0);
        tick("stall1");
        check("stall1_const", bus.cache_result, 16'h1002);
        drive(1'b0, 16'h0010, 16'h0, 2'b00, 3'd7, 1'b0, 1'b0, 4'b0100, 1'b1, ramp_line(16'h2000));
        tick("stall2");
        check("stall2_const", bus.cache_result, 16'h2002);
        drive(1'b0, 16'h0010, 16'h0, 2'b00, 3'd7, 1'b0, 1'b0, 4'b0001, 1'b0, '0);
        tick("stall3");
        check("stall3_const", bus.cache_result, 16'h2002);

        // ALU pass-through, then an illegal ldSt=11 that must not write
        drive(1'b1, 16'h1234, 16'h0, 2'b00, 3'd5, 1'b1, 1'b0, 4'b0000, 1'b0, '0);
        tick("alu");
        check("alu_result", bus.cache_result, 16'h1234);
        check("alu_dest", {13'b0, bus.destReg_addr_output}, 16'd5);
        check("alu_we", {15'b0, bus.we_output}, 16'd1);
        drive(1'b1, 16'h0004, 16'hDEAD, 2'b11, 3'd1, 1'b0, 1'b1, 4'b0100, 1'b0, '0);
        tick("ill");
        check("ill_const", bus.cache_result, 16'h0000);
        drive(1'b1, 16'h0004, 16'h0, 2'b01, 3'd1, 1'b1, 1'b1, 4'b0100, 1'b0, '0);
        tick("ill_rd");
        tick("ill_rd2");
        check("ill_rd_const", bus.cache_result, 16'h2002);

        // Asynchronous reset in the middle of a store
        drive(1'b1, 16'h0004, 16'h7777, 2'b10, 3'd6, 1'b1, 1'b1, 4'b0100, 1'b0, '0);
        tick("pre_rst");
        #2 reset = 1'b0;
        #1;
        check("arst_result", bus.cache_result, 16'h0);
        check("arst_dest", {13'b0, bus.destReg_addr_output}, 16'h0);
        check("arst_we", {15'b0, bus.we_output}, 16'h0);
        model_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        drive(1'b1, 16'h0004, 16'h0, 2'b01, 3'd1, 1'b1, 1'b1, 4'b0100, 1'b0, '0);
        tick("post_rst");
        check("post_rst_const", bus.cache_result, 16'h0000);
        drive(1'b1, 16'h0002, 16'h0, 2'b01, 3'd1, 1'b1, 1'b1, 4'b1000, 1'b0, '0);
        tick("post_rst3");
        check("post_rst3_const", bus.cache_result, 16'h0000);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [255:0] line;
            logic [1:0]   ldst;
            int           sel;
            for (int w = 0; w < 16; w++) line[w*16 +: 16] = 16'($urandom);
            sel = int'($urandom_range(0, 9));
            ldst = (sel < 4) ? 2'b01 : (sel < 7) ? 2'b10 : (sel < 9) ? 2'b00 : 2'b11;
            drive(($urandom_range(0, 4) != 0), 16'($urandom), 16'($urandom), ldst,
                  3'($urandom), 1'($urandom), ($urandom_range(0, 7) != 0),
                  4'($urandom), ($urandom_range(0, 5) == 0), line);
            tick("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
